// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// MulDivTypes
// Shared types and constants for the RV32M multiply/divide units.
//   DivOp    : divide operation encoding produced by decode (DIV/DIVU/REM/REMU)
//   DivState : divider FSM states
//   DIV_LATENCY and the RV32M divide-by-zero / signed-overflow result values.
// -----------------------------------------------------------------------------
package MulDivTypes;

    typedef enum logic [1:0] {
        DIVOP_DIV  = 2'd0,
        DIVOP_DIVU = 2'd1,
        DIVOP_REM  = 2'd2,
        DIVOP_REMU = 2'd3
    } DivOp;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } DivState;

    localparam int DIV_XLEN    = 32;
    localparam int DIV_LATENCY = DIV_XLEN + 1;

    localparam logic [DIV_XLEN-1:0] DIV_ZERO_QUOT = '1;
    localparam logic [DIV_XLEN-1:0] DIV_OVF_QUOT  = {1'b1, {(DIV_XLEN-1){1'b0}}};
    localparam logic [DIV_XLEN-1:0] DIV_OVF_REM   = '0;

    function automatic logic divOpSigned(DivOp op);
        return (op == DIVOP_DIV) || (op == DIVOP_REM);
    endfunction

    function automatic logic divOpRem(DivOp op);
        return (op == DIVOP_REM) || (op == DIVOP_REMU);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Issue/controller side <-> divider connection.
//   clear, stall        : controller abort and execute-stage stall
//   start, op, rs1, rs2 : division request and bypassed operands
//   busy, finished      : stall request and result-valid strobe
//   result              : quotient or remainder
// master = issue/controller side, slave = divider.
// -----------------------------------------------------------------------------
interface div_unit_if
    import MulDivTypes::*;
#(
    parameter int DATA_WIDTH = 32
) ();

    logic                  clear;
    logic                  stall;
    logic                  start;
    DivOp                  op;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    logic                  busy;
    logic                  finished;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output clear, stall, start, op, rs1, rs2,
        input  busy, finished, result
    );

    modport slave (
        input  clear, stall, start, op, rs1, rs2,
        output busy, finished, result
    );

endinterface

// File: rtl/div_sign_fixup.sv
// -----------------------------------------------------------------------------
// div_sign_fixup
// Combinational conditional two's-complement negation. Used to take operand
// magnitudes at start and to restore quotient/remainder signs at the end.
//   value  : input word
//   negate : 1 -> output is -value, 0 -> output is value
//   fixed  : result
// -----------------------------------------------------------------------------
module div_sign_fixup #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  negate,
    output logic [DATA_WIDTH-1:0] fixed
);

    assign fixed = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk, rst : clock and synchronous active-high reset
//   bus      : div_unit_if.slave (clear, stall, start, op, rs1, rs2 in;
//              busy, finished, result out)
// Normal ops take DATA_WIDTH CALC cycles and finish one cycle later;
// divide-by-zero and signed overflow finish the cycle after start.
// -----------------------------------------------------------------------------
module div_unit
    import MulDivTypes::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);

    DivState               state;
    DivOp                  opReg;
    logic                  quotNeg;
    logic                  remNeg;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic [DATA_WIDTH-1:0] remReg;
    logic [DATA_WIDTH-1:0] quotReg;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  finishedReg;
    logic [DATA_WIDTH-1:0] resultReg;

    logic                  startSigned;
    logic                  divZero;
    logic                  signedOvf;
    logic [DATA_WIDTH-1:0] absRs1;
    logic [DATA_WIDTH-1:0] absRs2;
    logic [DATA_WIDTH:0]   trial;
    logic                  trialOk;
    logic [DATA_WIDTH-1:0] nextRem;
    logic [DATA_WIDTH-1:0] nextQuot;
    logic [DATA_WIDTH-1:0] fixedQuot;
    logic [DATA_WIDTH-1:0] fixedRem;
    logic                  lastIter;

    // Start-time decode: operand magnitudes and special cases.
    assign startSigned = divOpSigned(bus.op);
    assign divZero     = (bus.rs2 == '0);
    assign signedOvf   = startSigned
                       && (bus.rs1 == DATA_WIDTH'(DIV_OVF_QUOT))
                       && (bus.rs2 == '1);

    div_sign_fixup #(.DATA_WIDTH(DATA_WIDTH)) absRs1Fix (
        .value (bus.rs1),
        .negate(startSigned & bus.rs1[DATA_WIDTH-1]),
        .fixed (absRs1)
    );

    div_sign_fixup #(.DATA_WIDTH(DATA_WIDTH)) absRs2Fix (
        .value (bus.rs2),
        .negate(startSigned & bus.rs2[DATA_WIDTH-1]),
        .fixed (absRs2)
    );

    // One restoring step. The full remainder is shifted so that divisors with
    // the MSB set (partial remainder >= 2^(W-1)) are still compared correctly.
    assign trial    = {remReg, dividend[DATA_WIDTH-1]} - {1'b0, divisor};
    assign trialOk  = ~trial[DATA_WIDTH];
    assign nextRem  = trialOk ? trial[DATA_WIDTH-1:0]
                              : {remReg[DATA_WIDTH-2:0], dividend[DATA_WIDTH-1]};
    assign nextQuot = {quotReg[DATA_WIDTH-2:0], trialOk};
    assign lastIter = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

    // Sign restoration on the final step's values so result is registered
    // on entry to DONE.
    div_sign_fixup #(.DATA_WIDTH(DATA_WIDTH)) quotFix (
        .value (nextQuot),
        .negate(quotNeg),
        .fixed (fixedQuot)
    );

    div_sign_fixup #(.DATA_WIDTH(DATA_WIDTH)) remFix (
        .value (nextRem),
        .negate(remNeg),
        .fixed (fixedRem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DIV_IDLE;
            opReg       <= DIVOP_DIV;
            quotNeg     <= 1'b0;
            remNeg      <= 1'b0;
            dividend    <= '0;
            divisor     <= '0;
            remReg      <= '0;
            quotReg     <= '0;
            cnt         <= '0;
            finishedReg <= 1'b0;
            resultReg   <= '0;
        end else if (bus.clear) begin
            state       <= DIV_IDLE;
            finishedReg <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (bus.start) begin
                        opReg    <= bus.op;
                        quotNeg  <= startSigned & (bus.rs1[DATA_WIDTH-1] ^ bus.rs2[DATA_WIDTH-1]);
                        remNeg   <= startSigned & bus.rs1[DATA_WIDTH-1];
                        dividend <= absRs1;
                        divisor  <= absRs2;
                        remReg   <= '0;
                        quotReg  <= '0;
                        cnt      <= '0;
                        if (divZero) begin
                            state       <= DIV_DONE;
                            finishedReg <= 1'b1;
                            resultReg   <= divOpRem(bus.op) ? bus.rs1 : DATA_WIDTH'(DIV_ZERO_QUOT);
                        end else if (signedOvf) begin
                            state       <= DIV_DONE;
                            finishedReg <= 1'b1;
                            resultReg   <= divOpRem(bus.op) ? DATA_WIDTH'(DIV_OVF_REM)
                                                            : DATA_WIDTH'(DIV_OVF_QUOT);
                        end else begin
                            state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    remReg   <= nextRem;
                    quotReg  <= nextQuot;
                    dividend <= dividend << 1;
                    cnt      <= cnt + 1'b1;
                    if (lastIter) begin
                        state       <= DIV_DONE;
                        finishedReg <= 1'b1;
                        resultReg   <= divOpRem(opReg) ? fixedRem : fixedQuot;
                    end
                end
                DIV_DONE: begin
                    if (!bus.stall) begin
                        state       <= DIV_IDLE;
                        finishedReg <= 1'b0;
                    end
                end
                default: begin
                    state       <= DIV_IDLE;
                    finishedReg <= 1'b0;
                end
            endcase
        end
    end

    // busy must follow stall within the DONE cycle so upstream stays frozen.
    assign bus.busy     = (state == DIV_CALC) || ((state == DIV_DONE) && bus.stall);
    assign bus.finished = finishedReg;
    assign bus.result   = resultReg;

endmodule
